// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package pipe_ctrl_pkg;

  localparam int MUL_LAT_DEFAULT = 4;
  localparam int CNT_W           = 4;

  // Mirrors OPCODE_MUL from the core opcode map in define.v.
  localparam logic [7:0] OPCODE_MUL = 8'h1A;

  typedef enum logic [1:0] {
    RUN,
    MUL_BUSY,
    MEM_WAIT
  } state_e;

  // Listed from highest to lowest priority.
  typedef enum logic [2:0] {
    HZ_NONE,
    HZ_MEM,
    HZ_BRANCH,
    HZ_MUL,
    HZ_LOAD_USE
  } hazard_e;

endpackage

// File: rtl/hazard_ctrl_mul_occ_counter.sv
// Down-counter tracking how many more EX cycles an in-flight MUL occupies.
module mul_occ_counter
  import pipe_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             load,
  input  logic             dec,
  input  logic [CNT_W-1:0] load_val,
  output logic [CNT_W-1:0] cnt,
  output logic             last,
  output logic             zero
);

  logic [CNT_W-1:0] cnt_d;
  logic [CNT_W-1:0] cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (load) begin
      cnt_d = load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt  = cnt_q;
  assign last = (cnt_q == CNT_W'(1));
  assign zero = (cnt_q == '0);

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: sole owner of stall, freeze and flush decisions
// for load-use, MUL occupancy, data-memory misses and taken branches.
module hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MUL_LAT = MUL_LAT_DEFAULT,
  parameter int REG_W   = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [7:0]       id_opcode,
  input  logic [REG_W-1:0] id_rs1,
  input  logic [REG_W-1:0] id_rs2,
  input  logic             id_uses_rs2,
  input  logic [7:0]       ex_opcode,
  input  logic             ex_memread,
  input  logic [REG_W-1:0] ex_rd,
  input  logic             mem_req,
  input  logic             mem_ready,
  input  logic             br_taken,
  output logic             id_stall,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             flush_ifid,
  output logic             flush_idex,
  output logic             ex_hold,
  output logic             mem_hold,
  output logic             busy
);

  localparam bit               MUL_STALLS = (MUL_LAT > 1);
  localparam logic [CNT_W-1:0] MUL_INIT   = CNT_W'(MUL_LAT - 1);

  state_e           state_q;
  state_e           state_d;
  state_e           eff_state;
  hazard_e          hz;
  logic             miss;
  logic             load_use;
  logic             mul_start;
  logic             cnt_clr;
  logic             cnt_load;
  logic             cnt_dec;
  logic [CNT_W-1:0] cnt;
  logic             cnt_last;
  logic             cnt_zero;

  // The ID opcode is part of the core's hazard interface; no current rule needs it.
  logic unused_id_opcode;
  assign unused_id_opcode = ^id_opcode;

  mul_occ_counter u_mul_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (cnt_clr),
    .load     (cnt_load),
    .dec      (cnt_dec),
    .load_val (MUL_INIT),
    .cnt      (cnt),
    .last     (cnt_last),
    .zero     (cnt_zero)
  );

  // A wait resumes into whatever the frozen counter says was in progress.
  always_comb begin
    miss      = mem_req & ~mem_ready;
    eff_state = state_q;
    if (state_q == MEM_WAIT) begin
      eff_state = cnt_zero ? RUN : MUL_BUSY;
    end
    load_use  = ex_memread && (ex_rd != '0) &&
                ((ex_rd == id_rs1) || (id_uses_rs2 && (ex_rd == id_rs2)));
    mul_start = MUL_STALLS && (eff_state == RUN) && (ex_opcode == OPCODE_MUL);

    hz = HZ_NONE;
    if (miss) begin
      hz = HZ_MEM;
    end else if (br_taken) begin
      hz = HZ_BRANCH;
    end else if (mul_start || ((eff_state == MUL_BUSY) && (cnt > CNT_W'(1)))) begin
      hz = HZ_MUL;
    end else if ((eff_state == RUN) && load_use) begin
      hz = HZ_LOAD_USE;
    end
  end

  always_comb begin
    id_stall   = 1'b0;
    pc_write   = 1'b1;
    ifid_write = 1'b1;
    flush_ifid = 1'b0;
    flush_idex = 1'b0;
    ex_hold    = 1'b0;
    mem_hold   = 1'b0;
    state_d    = eff_state;
    cnt_clr    = 1'b0;
    cnt_load   = 1'b0;
    cnt_dec    = 1'b0;

    if (eff_state == MUL_BUSY) begin
      cnt_dec = 1'b1;
      if (cnt <= CNT_W'(1)) begin
        state_d = RUN;
      end
    end

    case (hz)
      HZ_MEM: begin
        id_stall   = 1'b1;
        pc_write   = 1'b0;
        ifid_write = 1'b0;
        ex_hold    = 1'b1;
        mem_hold   = 1'b1;
        cnt_dec    = 1'b0;
        state_d    = MEM_WAIT;
      end
      HZ_BRANCH: begin
        id_stall   = 1'b1;
        flush_ifid = 1'b1;
        flush_idex = 1'b1;
        cnt_clr    = 1'b1;
        cnt_dec    = 1'b0;
        state_d    = RUN;
      end
      HZ_MUL: begin
        id_stall   = 1'b1;
        pc_write   = 1'b0;
        ifid_write = 1'b0;
        ex_hold    = 1'b1;
        if (mul_start) begin
          cnt_load = 1'b1;
          cnt_dec  = 1'b0;
          state_d  = MUL_BUSY;
        end
      end
      HZ_LOAD_USE: begin
        id_stall   = 1'b1;
        pc_write   = 1'b0;
        ifid_write = 1'b0;
      end
      default: ;
    endcase

    if (!rst_n) begin
      id_stall   = 1'b1;
      pc_write   = 1'b0;
      ifid_write = 1'b0;
      flush_ifid = 1'b1;
      flush_idex = 1'b1;
      ex_hold    = 1'b0;
      mem_hold   = 1'b0;
      cnt_clr    = 1'b1;
      cnt_load   = 1'b0;
      cnt_dec    = 1'b0;
      state_d    = RUN;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= RUN;
    end else begin
      state_q <= state_d;
    end
  end

  assign busy = rst_n && (state_q != RUN);

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard controller for the 5-stage core. It watches the decode, EX and M stages and drives the `stall` input of the decode-stage `control` unit to insert bubbles. It also drives the PC / IF-ID write enables, the pipeline flushes and the EX/M hold signals. It covers load-use hazards, multi-cycle MUL occupancy of EX, data-memory miss waits and taken-branch flushes, and is the single owner of all pipeline freeze/flush decisions.

## Interface
- `MUL_LAT`, default 4: EX cycles a MUL occupies. Legal range is 1..15; 1 means no MUL stall.
- `REG_W`, default 5: register index width.
- `clk` in 1: core clock.
- `rst_n` in 1: reset, synchronous, active-low.
- `id_opcode` in 8: opcode of the instruction in ID.
- `id_rs1` in REG_W: ID source register 1.
- `id_rs2` in REG_W: ID source register 2.
- `id_uses_rs2` in 1: ID instruction reads rs2.
- `ex_opcode` in 8: opcode currently in EX.
- `ex_memread` in 1: EX instruction is a load.
- `ex_rd` in REG_W: EX destination register.
- `mem_req` in 1: M stage accesses memory (memread|memwrite).
- `mem_ready` in 1: data memory completes the access this cycle.
- `br_taken` in 1: M stage resolves a taken branch/jump/iret.
- `id_stall` out 1: to `control.stall`; injects a bubble into ID/EX.
- `pc_write` out 1: PC register enable.
- `ifid_write` out 1: IF/ID register enable.
- `flush_ifid` out 1: zero the IF/ID register.
- `flush_idex` out 1: bubble the ID/EX register.
- `ex_hold` out 1: freeze the EX/M register and the ALU operands.
- `mem_hold` out 1: freeze the M/WB register.
- `busy` out 1: FSM is not in RUN.

## Operation
- States: RUN, MUL_BUSY, MEM_WAIT. The state and a 4-bit MUL counter are registered. Outputs are combinational from the state and the current inputs.
- Default outputs in RUN with no hazard: `pc_write`=1, `ifid_write`=1, all others 0.
- **Priority 1, memory wait** (any state): `mem_req & !mem_ready` causes the following.
  - Go to, or stay in, MEM_WAIT.
  - Outputs: `pc_write`=0, `ifid_write`=0, `ex_hold`=1, `mem_hold`=1, `id_stall`=1.
  - Flushes are 0. A `br_taken` seen during the wait is ignored until `mem_ready`.
  - In the `mem_ready` cycle, return to the saved resume state (RUN, or MUL_BUSY if the counter is nonzero). The other rules are evaluated normally in that cycle.
- **Priority 2, branch flush** (RUN/MUL_BUSY): `br_taken` causes the following.
  - Outputs: `flush_ifid`=1, `flush_idex`=1, `id_stall`=1, `pc_write`=1 (the target is loaded).
  - The MUL counter is cleared and the state goes to RUN.
- **Priority 3, MUL occupancy**: in RUN, `ex_opcode==OPCODE_MUL` with `MUL_LAT>1` causes the following.
  - Load the counter with `MUL_LAT-1` and go to MUL_BUSY.
  - Outputs in that cycle and every MUL_BUSY cycle with counter>1: `ex_hold`=1, `pc_write`=0, `ifid_write`=0, `id_stall`=1.
  - Counter decrements each non-MEM_WAIT cycle. The cycle in which the counter equals 1 releases the hold, and the state returns to RUN at the next edge.
- **Priority 4, load-use** (RUN only): the hazard is `ex_memread & ex_rd!=0 & (ex_rd==id_rs1 | (id_uses_rs2 & ex_rd==id_rs2))`.
  - Outputs: `id_stall`=1, `pc_write`=0, `ifid_write`=0 for exactly the cycle the hazard is visible.
  - The hazard clears naturally once the load advances.
- `busy`=1 whenever the state is not RUN.
- Reset applies on a clock edge with `rst_n`=0, from any state including mid-MUL or mid-wait:
  - state goes to RUN and the counter to 0;
  - outputs while in reset: `id_stall`=1, `pc_write`=0, `ifid_write`=0, `flush_ifid`=1, `flush_idex`=1, `ex_hold`=0, `mem_hold`=0, `busy`=0.

## Timing
- Every output is valid in the same cycle as its causing input. `control` samples `id_stall` at the next rising edge, so a bubble reaches EX one cycle after detection.
- Load-use costs 1 bubble.
- A MUL costs `MUL_LAT-1` stall cycles.
- A taken branch costs 2 flushed slots.
- A miss costs N cycles, where N is the number of cycles with `mem_ready`=0.
- `mem_ready` may be high in the same cycle `mem_req` rises. That case is a hit, with no state change.

## Structure
- Package `pipe_ctrl_pkg` holds:
  - the state enum (RUN, MUL_BUSY, MEM_WAIT);
  - the default `MUL_LAT` constant;
  - the hazard-priority encoding.
- Opcodes come from the existing `define.v` (`OPCODE_MUL` and others).
- One sub-module, `mul_occ_counter`: load, decrement, clear, and a `last` flag.

## Test plan
- Load-use: `LDW r3` in EX, `ADD r4,r3,r5` in ID -> exactly one cycle with `id_stall`=1 and `pc_write`=0, then normal flow.
- Load to r0, consumer reads r0 -> no stall.
- MUL with `MUL_LAT`=4 -> `ex_hold`=1 for 3 cycles, `busy` 1→0 afterwards. Repeat with `MUL_LAT`=1 -> no hold.
- `mem_req`=1 with `mem_ready` low for 5 cycles -> `mem_hold`/`ex_hold`=1 for 5 cycles. Raise `br_taken` mid-wait -> no flush until `mem_ready`, then a 1-cycle flush.
- Miss raised during MUL_BUSY with counter=2 -> counter frozen through the wait, then 1 more hold cycle, then RUN.
- `rst_n`=0 mid-MUL -> the next edge gives RUN, counter 0, and the reset output values listed above.
